instr_register_pipe: RTL and testbench
======================================

Name: instr_register_pipe

Overview:
- Parametrised successor to the team's instruction register. It accepts opcode/operand requests through a valid/ready handshake and computes the result in a registered execute stage.
- Each result is stored together with its opcode, operands and status in a DEPTH-entry instruction array, and any entry can be read back at any time.
- It adds a bulk-clear state machine, a divide-by-zero flag and a per-entry valid bit.
- It sits between the instruction-issuing test/driver logic and the checker/scoreboard, connected through the tb_ifc-style interface.

Parameters:
- DEPTH, 32, number of array entries; power of two, at least 2.
- OPW, 32, signed operand width.
- RESW, 64, signed result width; must be at least 2*OPW.
- PTRW, $clog2(DEPTH), derived localparam giving the pointer width.

Ports:
- clk, in, 1, single clock; all state is updated on its rising edge.
- reset, in, 1, asynchronous, active-high; clears the pipeline, the array and the FSM.
- load_en, in, 1, request valid.
- load_ready, out, 1, request accepted on an edge where load_en && load_ready.
- opcode, in, opcode_t, operation to perform.
- operand_a, in, OPW, signed operand A.
- operand_b, in, OPW, signed operand B.
- write_pointer, in, PTRW, destination entry.
- read_pointer, in, PTRW, entry to read.
- instruction_word, out, instr_t, combinational read of iw_reg[read_pointer].
- clear_all, in, 1, pulse that requests a bulk clear.
- busy, out, 1, high while the pipeline holds ops or a clear is running.

Behaviour:
- Reset values:
  - Every entry becomes {opc:ZERO, a:0, b:0, res:0, div_err:0, valid:0}.
  - s1_v = s2_v = 0.
  - FSM state = IDLE, load_ready = 1, busy = 0.
- Pipeline:
  - Accept at edge N loads S1 with {opcode, a, b, ptr}.
  - Edge N+1 loads S2 with the computed result.
  - Edge N+2 writes the array entry and sets valid = 1.
  - The read port therefore shows the new entry after edge N+2.
  - Full throughput: one accept per cycle with no stalls in IDLE.
- Arithmetic (signed):
  - ZERO gives 0.
  - PASSA and PASSB give the selected operand, sign-extended to RESW.
  - ADD and SUB use OPW+1-bit results, sign-extended.
  - MULT keeps the full 2*OPW-bit product, sign-extended.
  - DIV truncates toward zero; MOD takes the sign of the dividend.
  - DIV or MOD with b == 0 gives res = 0 and div_err = 1; div_err = 0 for all other cases.
  - Undefined opcode encodings give res = 0, div_err = 0.
- Ordering:
  - Writes retire in acceptance order, so two in-flight ops to the same pointer leave the later one stored.
  - Reading the entry being written in the same cycle returns the old contents until the edge.
- FSM, states IDLE and CLEAR:
  - load_ready = (state == IDLE) && !clear_all.
  - IDLE -> CLEAR when clear_all = 1:
    - S1 and S2 are squashed (v = 0) and never retire.
    - clr_idx is set to 0.
    - A load_en in that same cycle is not accepted.
  - In CLEAR, each cycle writes iw_reg[clr_idx] to its reset value and increments clr_idx.
  - CLEAR -> IDLE on the edge that clears entry DEPTH-1, so a clear takes exactly DEPTH cycles.
  - clear_all asserted during CLEAR is ignored and does not restart the sweep.
- busy = s1_v | s2_v | (state == CLEAR).
- Reset mid-operation, mid-clear or with an op in flight: immediate return to the reset values; no partial write survives.
- Pointer wrap: pointers are PTRW bits and are used modulo DEPTH; there is no out-of-range case.

Decomposition:
- instr_register_pkg holds:
  - opcode_t: 4-bit enum with ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD.
  - instr_t: packed struct {opc, op_a, op_b, res, div_err, valid}, parametrised through package localparams OPW/RESW that match the module defaults.
  - The clear FSM state enum.
- One sub-module, instr_alu: combinational opcode/operand to {res, div_err}, instantiated between S1 and S2.
- The array, pipeline registers and FSM stay in instr_register_pipe.

Test Plan:
- Reset, then read all pointers -> every entry {ZERO, 0, 0, 0, 0, valid = 0}, load_ready = 1, busy = 0.
- Back-to-back loads: ADD a=5, b=-7 to ptr 3; MULT a=-3, b=4 to ptr 4 on the next cycle. Reading ptr 3 two edges after its accept gives res = -2; ptr 4 one cycle later gives res = -12; both have valid = 1.
- DIV a=7, b=0 to ptr 9 -> res = 0, div_err = 1. Then DIV a=-7, b=2 -> res = -3. MOD a=-7, b=2 -> res = -1, div_err = 0.
- MULT a=32'h7FFFFFFF, b=32'h7FFFFFFF -> res = 64'h3FFFFFFF00000001, with no truncation.
- Write ptr 31 then ptr 0. Assert clear_all together with load_en while an op is in S1 -> that load is refused and the in-flight op never appears. busy is high for 32 cycles, then all entries are zero; loads are accepted again on the next cycle.
- Assert reset in the middle of a clear sweep at entry 10, with entries 20..31 still holding data -> all outputs return to their reset values immediately, and the FSM is in IDLE after reset drops.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register:
// opcodes, the stored entry layout and the clear FSM states.
package instr_register_pkg;

    localparam int OPW  = 32;
    localparam int RESW = 64;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t                opc;
        logic signed [OPW-1:0]  op_a;
        logic signed [OPW-1:0]  op_b;
        logic signed [RESW-1:0] res;
        logic                   div_err;
        logic                   valid;
    } instr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/instr_register_pipe_if.sv
// Request/readback bundle between the issuing driver and the
// instruction register.
interface instr_register_pipe_if
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
) ();

    localparam int PTRW = $clog2(DEPTH);

    logic                  load_en;
    logic                  load_ready;
    opcode_t               opcode;
    logic signed [OPW-1:0] operand_a;
    logic signed [OPW-1:0] operand_b;
    logic [PTRW-1:0]       write_pointer;
    logic [PTRW-1:0]       read_pointer;
    instr_t                instruction_word;
    logic                  clear_all;
    logic                  busy;

    modport master (
        output load_en, opcode, operand_a, operand_b,
        output write_pointer, read_pointer, clear_all,
        input  load_ready, instruction_word, busy
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b,
        input  write_pointer, read_pointer, clear_all,
        output load_ready, instruction_word, busy
    );

endinterface

// File: rtl/instr_alu.sv
// Combinational signed execute unit: opcode and operands to
// a sign-extended result plus a divide-by-zero flag.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OPW  = 32,
    parameter int RESW = 64
) (
    input  opcode_t                opc,
    input  logic signed [OPW-1:0]  a,
    input  logic signed [OPW-1:0]  b,
    output logic signed [RESW-1:0] res,
    output logic                   div_err
);

    logic signed [RESW-1:0] ea;
    logic signed [RESW-1:0] eb;
    logic                   b_zero;

    // Working at RESW keeps ADD/SUB carries and the full product,
    // and makes min/-1 division representable.
    assign ea     = RESW'(a);
    assign eb     = RESW'(b);
    assign b_zero = (b == '0);

    always_comb begin
        res     = '0;
        div_err = 1'b0;
        unique case (opc)
            ZERO:  res = '0;
            PASSA: res = ea;
            PASSB: res = eb;
            ADD:   res = ea + eb;
            SUB:   res = ea - eb;
            MULT:  res = ea * eb;
            DIV: begin
                if (b_zero) div_err = 1'b1;
                else        res = ea / eb;
            end
            MOD: begin
                if (b_zero) div_err = 1'b1;
                else        res = ea % eb;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_pipe.sv
// Two-stage instruction register: S1 latches the request, S2 the
// ALU result, then the entry retires into the array.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int OPW   = 32,
    parameter int RESW  = 64
) (
    input logic            clk,
    input logic            reset,
    instr_register_pipe_if.slave bus
);

    localparam int PTRW = $clog2(DEPTH);
    localparam instr_t IW_RST = '0;

    clr_state_t            state;
    logic [PTRW-1:0]       clr_idx;
    instr_t                iw_reg [DEPTH];

    logic                  s1_v;
    opcode_t               s1_opc;
    logic signed [OPW-1:0] s1_a;
    logic signed [OPW-1:0] s1_b;
    logic [PTRW-1:0]       s1_ptr;

    logic                  s2_v;
    instr_t                s2_iw;
    logic [PTRW-1:0]       s2_ptr;

    logic signed [RESW-1:0] alu_res;
    logic                   alu_err;
    logic                   accept;
    logic                   clr_go;

    assign bus.load_ready = (state == IDLE) && !bus.clear_all;
    assign accept = bus.load_en && bus.load_ready;
    assign clr_go = (state == IDLE) && bus.clear_all;
    assign bus.busy = s1_v | s2_v | (state == CLEAR);
    assign bus.instruction_word = iw_reg[bus.read_pointer];

    instr_alu #(.OPW(OPW), .RESW(RESW)) u_alu (
        .opc     (s1_opc),
        .a       (s1_a),
        .b       (s1_b),
        .res     (alu_res),
        .div_err (alu_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_idx <= '0;
            s1_v    <= 1'b0;
            s1_opc  <= ZERO;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_ptr  <= '0;
            s2_v    <= 1'b0;
            s2_iw   <= IW_RST;
            s2_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) iw_reg[i] <= IW_RST;
        end else begin
            s1_v <= accept;
            // A starting clear squashes whatever sits in S1/S2.
            s2_v <= s1_v && !clr_go;
            if (accept) begin
                s1_opc <= bus.opcode;
                s1_a   <= bus.operand_a;
                s1_b   <= bus.operand_b;
                s1_ptr <= bus.write_pointer;
            end
            if (s1_v) begin
                s2_iw  <= '{opc: s1_opc, op_a: s1_a, op_b: s1_b,
                            res: alu_res, div_err: alu_err,
                            valid: 1'b1};
                s2_ptr <= s1_ptr;
            end
            if (s2_v && !clr_go) iw_reg[s2_ptr] <= s2_iw;
            unique case (state)
                IDLE: begin
                    if (bus.clear_all) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    iw_reg[clr_idx] <= IW_RST;
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == PTRW'(DEPTH - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Scoreboard bench for instr_register_pipe: expected entries are
// queued on accept and compared when they retire.
module tb_instr_register_pipe;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;

    typedef struct {
        logic [4:0] ptr;
        instr_t     e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_register_pipe_if #(.DEPTH(DEPTH)) bus ();

    instr_register_pipe #(.DEPTH(DEPTH), .OPW(32), .RESW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic longint model_res(opcode_t op, int a, int b);
        longint la = longint'(a);
        longint lb = longint'(b);
        case (op)
            PASSA: return la;
            PASSB: return lb;
            ADD:   return la + lb;
            SUB:   return la - lb;
            MULT:  return la * lb;
            DIV:   return (b == 0) ? 64'sd0 : la / lb;
            MOD:   return (b == 0) ? 64'sd0 : la % lb;
            default: return 64'sd0;
        endcase
    endfunction

    function automatic bit model_err(opcode_t op, int b);
        return (op == DIV || op == MOD) && b == 0;
    endfunction

    task automatic issue(input opcode_t op,
                         input logic signed [31:0] a,
                         input logic signed [31:0] b,
                         input logic [4:0] ptr,
                         input logic signed [63:0] res,
                         input logic err,
                         input bit keep);
        exp_t x;
        @(negedge clk);
        bus.load_en = 1'b1;
        bus.opcode = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.write_pointer = ptr;
        #1;
        checks++;
        if (bus.load_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b expected 1", bus.load_ready);
        end
        @(posedge clk);
        x.ptr = ptr;
        x.e.opc = op;
        x.e.op_a = a;
        x.e.op_b = b;
        x.e.res = res;
        x.e.div_err = err;
        x.e.valid = 1'b1;
        if (keep) sb.push_back(x);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.load_en = 1'b0;
        bus.clear_all = 1'b0;
    endtask

    task automatic check_front(input int nedges, input string name);
        exp_t x;
        repeat (nedges) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            x = sb.pop_front();
            bus.read_pointer = x.ptr;
            #1;
            if (bus.instruction_word !== x.e) begin
                errors++;
                $display("FAIL %s: ptr %0d got %h expected %h",
                         name, x.ptr, bus.instruction_word, x.e);
            end
        end
    endtask

    task automatic check_zero(input int lo, input int hi,
                              input string name);
        for (int i = lo; i <= hi; i++) begin
            bus.read_pointer = 5'(i);
            #1;
            checks++;
            if (bus.instruction_word !== '0) begin
                errors++;
                $display("FAIL %s: ptr %0d got %h expected 0",
                         name, i, bus.instruction_word);
            end
        end
    endtask

    task automatic check_ctl(input logic ready, input logic bsy,
                             input string name);
        checks++;
        if (bus.load_ready !== ready || bus.busy !== bsy) begin
            errors++;
            $display("FAIL %s: ready/busy got %b%b expected %b%b",
                     name, bus.load_ready, bus.busy, ready, bsy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_zero(0, DEPTH - 1, "reset_entry");
        check_ctl(1'b1, 1'b0, "reset_ctl");
    endtask

    task automatic test_back_to_back();
        issue(ADD, 5, -7, 5'd3, -64'sd2, 1'b0, 1'b1);
        issue(MULT, -3, 4, 5'd4, -64'sd12, 1'b0, 1'b1);
        drive_idle();
        bus.read_pointer = 5'd3;
        #1;
        checks++;
        if (bus.instruction_word.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: valid got %b expected 0",
                     bus.instruction_word.valid);
        end
        check_ctl(1'b1, 1'b1, "b2b_busy");
        check_front(1, "b2b_add");
        check_front(1, "b2b_mult");
    endtask

    task automatic test_div();
        issue(DIV, 7, 0, 5'd9, 64'sd0, 1'b1, 1'b1);
        issue(DIV, -7, 2, 5'd10, -64'sd3, 1'b0, 1'b1);
        issue(MOD, -7, 2, 5'd11, -64'sd1, 1'b0, 1'b1);
        drive_idle();
        for (int i = 0; i < 3; i++) check_front(2, "div");
    endtask

    task automatic test_wide();
        issue(MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd12,
              64'sh3FFFFFFF00000001, 1'b0, 1'b1);
        issue(PASSB, 9, -1, 5'd13, -64'sd1, 1'b0, 1'b1);
        issue(SUB, 32'h80000000, 1, 5'd14,
              64'shFFFFFFFF7FFFFFFF, 1'b0, 1'b1);
        issue(opcode_t'(4'd12), 3, 4, 5'd15, 64'sd0, 1'b0, 1'b1);
        drive_idle();
        for (int i = 0; i < 4; i++) check_front(2, "wide");
    endtask

    task automatic test_random();
        opcode_t op;
        int a;
        int b;
        for (int i = 0; i < 8; i++) begin
            op = opcode_t'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 0 : $urandom_range(0, 20) - 10;
            if (i == 3) op = MOD;
            issue(op, a, b, 5'(16 + i), model_res(op, a, b),
                  model_err(op, b), 1'b1);
        end
        drive_idle();
        for (int i = 0; i < 8; i++) check_front(2, "random");
    endtask

    task automatic test_same_ptr();
        issue(ADD, 1, 1, 5'd24, 64'sd2, 1'b0, 1'b0);
        issue(SUB, 1, 1, 5'd24, 64'sd0, 1'b0, 1'b1);
        drive_idle();
        check_front(2, "same_ptr");
    endtask

    task automatic test_clear();
        int n;
        issue(ADD, 1, 2, 5'd31, 64'sd3, 1'b0, 1'b1);
        issue(ADD, 4, 5, 5'd0, 64'sd9, 1'b0, 1'b1);
        drive_idle();
        check_front(2, "pre_clear");
        check_front(1, "pre_clear");
        issue(PASSA, 77, 0, 5'd5, 64'sd77, 1'b0, 1'b0);
        @(negedge clk);
        bus.clear_all = 1'b1;
        bus.load_en = 1'b1;
        bus.write_pointer = 5'd6;
        bus.operand_a = 88;
        #1;
        check_ctl(1'b0, 1'b1, "clear_refuse");
        @(negedge clk);
        bus.clear_all = 1'b0;
        bus.load_en = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            bus.clear_all = (n == 10);
            @(negedge clk);
        end
        bus.clear_all = 1'b0;
        #1;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles expected %0d",
                     n, DEPTH);
        end
        check_zero(0, DEPTH - 1, "clear_entry");
        check_ctl(1'b1, 1'b0, "clear_done");
        issue(PASSA, 42, 0, 5'd7, 64'sd42, 1'b0, 1'b1);
        drive_idle();
        check_front(2, "post_clear");
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 20; i < 32; i++)
            issue(PASSA, i, 0, 5'(i), 64'(i), 1'b0, 1'b1);
        drive_idle();
        for (int i = 0; i < 12; i++) check_front(1, "fill");
        @(negedge clk);
        bus.clear_all = 1'b1;
        @(negedge clk);
        bus.clear_all = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.read_pointer = 5'd20;
        #1;
        checks++;
        if (bus.instruction_word.valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_data: valid got %b expected 1",
                     bus.instruction_word.valid);
        end
        reset = 1'b1;
        #1;
        check_ctl(1'b1, 1'b0, "mid_reset_ctl");
        check_zero(20, DEPTH - 1, "mid_reset_entry");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_ctl(1'b1, 1'b0, "after_reset_idle");
        issue(SUB, 10, 3, 5'd1, 64'sd7, 1'b0, 1'b1);
        drive_idle();
        check_front(2, "after_reset_op");
    endtask

    initial begin
        reset = 1'b1;
        bus.load_en = 1'b0;
        bus.clear_all = 1'b0;
        bus.opcode = ZERO;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.write_pointer = '0;
        bus.read_pointer = '0;
        test_reset();
        test_back_to_back();
        test_div();
        test_wide();
        test_random();
        test_same_ptr();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
